// File: rtl/dpram_stream_reader.sv
// Read-side sequencer for the dual-port coefficient RAM (2-cycle read).
// Streams 2*len words as even/odd pairs through a credit-limited FIFO.
module dpram_stream_reader #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW-1:0]    len,
    output logic             busy,
    output logic             done,
    output logic             ena,
    output logic             enb,
    output logic             wea,
    output logic             web,
    output logic [AW-1:0]    addra,
    output logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] douta,
    input  logic [WIDTH-1:0] doutb,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data_a,
    output logic [WIDTH-1:0] m_data_b,
    output logic             m_last
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   k_q, k_d;
    logic [1:0]      pv_q, pv_d;
    logic [1:0]      pl_q, pl_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            issue;
    logic            last_issue;
    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic [CW:0]     occ;
    logic [AW-1:0]   addr_k;
    logic [EW-1:0]   head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy counts reads still in the RAM pipe, so pushes never overflow.
    assign occ = {1'b0, cnt_q} + (CW + 1)'(pv_q[0]) + (CW + 1)'(pv_q[1]);
    assign issue = (state_q == ISSUE) && (occ < (CW + 1)'(FIFO_DEPTH));
    assign last_issue = (k_q == len_q - 1'b1);
    assign addr_k = base_q + {k_q[AW-2:0], 1'b0};
    assign push = pv_q[1];
    assign fifo_nonempty = (cnt_q != '0);
    assign pop = fifo_nonempty && m_ready;
    assign head = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            k_q     <= k_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {pl_q[1], douta, doutb};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issue && last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pv_q == 2'b00 &&
                    (cnt_q == '0 || (cnt_q == CW'(1) && pop))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        k_d    = k_q;
        if (state_q == IDLE && start) begin
            base_d = base_addr;
            len_d  = len;
            k_d    = '0;
        end else if (issue) begin
            k_d = k_q + 1'b1;
        end
        pv_d  = {pv_q[0], issue};
        pl_d  = {pl_q[0], issue && last_issue};
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        busy     = (state_q == ISSUE) || (state_q == DRAIN);
        done     = (state_q == FIN);
        ena      = issue;
        enb      = issue;
        wea      = 1'b0;
        web      = 1'b0;
        addra    = issue ? addr_k : '0;
        addrb    = issue ? addr_k + 1'b1 : '0;
        m_valid  = fifo_nonempty;
        m_last   = fifo_nonempty ? head[EW-1] : 1'b0;
        m_data_a = fifo_nonempty ? head[2*WIDTH-1:WIDTH] : '0;
        m_data_b = fifo_nonempty ? head[WIDTH-1:0] : '0;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench for dpram_stream_reader with a 2-cycle RAM model.
// Expected pairs and addresses are queued at start and popped on output.
module tb_dpram_stream_reader;

    localparam int W  = 16;
    localparam int D  = 512;
    localparam int FD = 4;
    localparam int AW = 9;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          ena;
    logic          enb;
    logic          wea;
    logic          web;
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [W-1:0]  douta;
    logic [W-1:0]  doutb;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data_a;
    logic [W-1:0]  m_data_b;
    logic          m_last;

    dpram_stream_reader #(
        .WIDTH(W),
        .DEPTH(D),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .ena(ena),
        .enb(enb),
        .wea(wea),
        .web(web),
        .addra(addra),
        .addrb(addrb),
        .douta(douta),
        .doutb(doutb),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data_a(m_data_a),
        .m_data_b(m_data_b),
        .m_last(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ram [D];
    logic [W-1:0] r1a, r1b;

    always @(posedge clk) begin
        if (ena) begin
            r1a <= ram[addra];
            r1b <= ram[addrb];
        end
        douta <= r1a;
        doutb <= r1b;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int issued = 0;
    int popped = 0;
    int ena_cnt, done_cnt, valid_cnt, blk_pops;
    int first_valid_rel, last_rel, done_rel;
    int ready_mode = 0;
    logic            stall_q = 1'b0;
    logic [2*W:0]    held;
    logic [2*W:0]    exp_q [$];
    logic [AW-1:0]   addr_q [$];

    task automatic monitor();
        int rel;
        logic [2*W:0]  got;
        logic [2*W:0]  ex;
        logic [AW-1:0] ea;
        logic [AW-1:0] eb;
        rel = cyc - start_cyc;
        got = {m_last, m_data_a, m_data_b};
        if (stall_q) begin
            checks++;
            if (m_valid !== 1'b1 || got !== held) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b %h need v=1 %h",
                         cyc, m_valid, got, held);
            end
        end
        if (ena === 1'b1) begin
            ena_cnt++;
            issued++;
            checks++;
            if (enb !== 1'b1 || wea !== 1'b0 || web !== 1'b0) begin
                errors++;
                $display("FAIL port_en cyc=%0d enb=%b wea=%b web=%b need 1,0,0",
                         cyc, enb, wea, web);
            end
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL extra_issue cyc=%0d addra=%0d need no issue",
                         cyc, addra);
            end else begin
                ea = addr_q.pop_front();
                eb = ea + 1'b1;
                if (addra !== ea || addrb !== eb) begin
                    errors++;
                    $display("FAIL addr cyc=%0d got %0d,%0d need %0d,%0d",
                             cyc, addra, addrb, ea, eb);
                end
            end
            checks++;
            if (issued - popped > FD) begin
                errors++;
                $display("FAIL credit cyc=%0d outstanding=%0d need <=%0d",
                         cyc, issued - popped, FD);
            end
        end
        if (m_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid_rel < 0) first_valid_rel = rel;
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_pair cyc=%0d got %h need none", cyc, got);
            end else begin
                ex = exp_q.pop_front();
                if (got !== ex) begin
                    errors++;
                    $display("FAIL pair cyc=%0d got %h need %h", cyc, got, ex);
                end
            end
            popped++;
            blk_pops++;
            if (m_last === 1'b1) last_rel = rel;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_rel = rel;
        end
        stall_q = (m_valid === 1'b1 && m_ready !== 1'b1);
        held = got;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        monitor();
    endtask

    task automatic begin_block(input int b, input int l);
        logic [AW-1:0] a;
        logic [AW-1:0] a1;
        ena_cnt = 0;
        done_cnt = 0;
        valid_cnt = 0;
        blk_pops = 0;
        first_valid_rel = -1;
        last_rel = -1;
        done_rel = -1;
        for (int k = 0; k < l; k++) begin
            a = AW'(b + 2 * k);
            a1 = a + 1'b1;
            addr_q.push_back(a);
            exp_q.push_back({(k == l - 1), ram[a], ram[a1]});
        end
        start = 1'b1;
        base_addr = AW'(b);
        len = AW'(l);
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int trail);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout got no done in %0d cycles need done",
                     budget);
        end
        repeat (trail) tick();
    endtask

    task automatic flush();
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        popped = 0;
        stall_q = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*AW+2*W+7:0] outs;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        m_ready = 1'b1;
        flush();
        tick();
        tick();
        outs = {busy, done, ena, enb, wea, web, m_valid, m_last,
                addra, addrb, m_data_a, m_data_b};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outs got %h need 0", outs);
        end
        rst_n = 1'b1;
        tick();
        outs = {busy, done, ena, enb, wea, web, m_valid, m_last,
                addra, addrb, m_data_a, m_data_b};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL idle_outs got %h need 0", outs);
        end
    endtask

    task automatic test_basic();
        ready_mode = 0;
        begin_block(0, 4);
        wait_done(50, 3);
        checks++;
        if (first_valid_rel != 4) begin
            errors++;
            $display("FAIL basic_first got %0d need 4", first_valid_rel);
        end
        checks++;
        if (last_rel != 7) begin
            errors++;
            $display("FAIL basic_last got %0d need 7", last_rel);
        end
        checks++;
        if (done_rel != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done got cyc %0d cnt %0d need 8 1",
                     done_rel, done_cnt);
        end
        checks++;
        if (ena_cnt != 4 || blk_pops != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count got en %0d pops %0d left %0d need 4 4 0",
                     ena_cnt, blk_pops, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        begin_block(8, 6);
        wait_done(200, 5);
        ready_mode = 0;
        checks++;
        if (blk_pops != 6 || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_count got pops %0d left %0d done %0d need 6 0 1",
                     blk_pops, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_wrap();
        ready_mode = 0;
        begin_block(510, 2);
        wait_done(50, 3);
        checks++;
        if (blk_pops != 2 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_count got pops %0d left %0d/%0d need 2 0/0",
                     blk_pops, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_zero_len();
        ready_mode = 0;
        begin_block(0, 0);
        checks++;
        if (done !== 1'b1 || done_rel != 1) begin
            errors++;
            $display("FAIL zero_done got done=%b rel=%0d need 1 at 1",
                     done, done_rel);
        end
        repeat (6) tick();
        checks++;
        if (ena_cnt != 0 || valid_cnt != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_quiet got en %0d valid %0d done %0d need 0 0 1",
                     ena_cnt, valid_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*AW+2*W+7:0] outs;
        int n;
        ready_mode = 0;
        begin_block(0, 8);
        n = 0;
        while (blk_pops < 2 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (blk_pops < 2) begin
            errors++;
            $display("FAIL mid_progress got pops %0d need 2", blk_pops);
        end
        tick();
        rst_n = 1'b0;
        stall_q = 1'b0;
        tick();
        outs = {busy, done, ena, enb, wea, web, m_valid, m_last,
                addra, addrb, m_data_a, m_data_b};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outs got %h need 0", outs);
        end
        flush();
        rst_n = 1'b1;
        done_cnt = 0;
        ena_cnt = 0;
        valid_cnt = 0;
        repeat (6) tick();
        checks++;
        if (done_cnt != 0 || ena_cnt != 0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL mid_quiet got done %0d en %0d valid %0d need 0 0 0",
                     done_cnt, ena_cnt, valid_cnt);
        end
        begin_block(0, 2);
        wait_done(50, 3);
        checks++;
        if (blk_pops != 2 || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL mid_restart got pops %0d left %0d done %0d need 2 0 1",
                     blk_pops, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_start_busy();
        ready_mode = 0;
        begin_block(20, 5);
        tick();
        tick();
        start = 1'b1;
        base_addr = AW'(100);
        len = AW'(3);
        tick();
        start = 1'b0;
        wait_done(50, 10);
        checks++;
        if (blk_pops != 5 || ena_cnt != 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start got pops %0d en %0d done %0d need 5 5 1",
                     blk_pops, ena_cnt, done_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL busy_left got %0d/%0d need 0/0",
                     exp_q.size(), addr_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) ram[i] = W'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
